// File: rtl/cpu_pkg.sv
// Shared core definitions: arbiter state encoding, port identifiers, default bus widths.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int unsigned AW_DEF = 32;
    localparam int unsigned DW_DEF = 32;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational port picker for mem_arbiter; MEM_ARB_RR_EN selects round-robin on contention,
// otherwise the data port has fixed priority over fetch.
module mem_arb_pick
    import cpu_pkg::*;
(
    input  logic eligible_i,
    input  logic eligible_d,
    input  logic rr_ptr,
    output logic grant_valid,
    output logic grant_port
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        grant_valid = eligible_i | eligible_d;
        if (eligible_i && eligible_d) begin
            grant_port = rr_ptr;
        end else begin
            grant_port = eligible_d ? PORT_D : PORT_I;
        end
    end
`else
    logic unused_rr_ptr;
    assign unused_rr_ptr = rr_ptr;

    always_comb begin
        grant_valid = eligible_i | eligible_d;
        grant_port  = eligible_d ? PORT_D : PORT_I;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data accesses onto one variable-latency memory port.
// Define MEM_ARB_RR_EN for round-robin arbitration on contention (default: data wins).
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_valid,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_valid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);

    arb_state_t state;
    logic       rr_ptr;
    logic       grant_valid;
    logic       grant_port;
    logic       eligible_i;
    logic       eligible_d;

`ifndef MEM_ARB_RR_EN
    assign rr_ptr = PORT_D;
`endif

    // A port still showing its valid pulse is masked so its held req is not re-granted.
    assign eligible_i = if_req & ~if_valid;
    assign eligible_d = d_req & ~d_valid;
    assign busy       = (state != IDLE);

    mem_arb_pick u_pick (
        .eligible_i  (eligible_i),
        .eligible_d  (eligible_d),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    // The mem_* output flops double as the grant registers for the in-flight transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            d_valid   <= 1'b0;
            d_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
            rr_ptr    <= PORT_D;
`endif
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        mem_req <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        rr_ptr  <= ~grant_port;
`endif
                        if (grant_port == PORT_D) begin
                            state     <= BUSY_D;
                            mem_we    <= d_we;
                            mem_be    <= d_be;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            state     <= BUSY_I;
                            mem_we    <= 1'b0;
                            mem_be    <= '1;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        if_valid <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        d_valid <= 1'b1;
                        d_rdata <= mem_we ? '0 : mem_rdata;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
